ssc_wb_arbiter: RTL and testbench

- Shares the register bank's single write port between two requesters: ALU writeback and memory-load writeback.
- Each requester uses a valid/ready handshake. Output is registered and drives the bank's write-enable, destination, write-data and flag-update inputs.
- Sits between the execute/memory stages and the register bank. All state advances only on cycles where clk_en=1.

---
 rtl/ssc_pkg.sv | 16 +
 rtl/ssc_rr_arb2.sv | 47 ++++
 rtl/ssc_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_ssc_wb_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssc_pkg.sv
// ssc_pkg: shared constants and types for the register-bank writeback slice.
// Requester indices double as bit positions in request/grant vectors.
package ssc_pkg;

   localparam int REG_PC    = 0;
   localparam int REG_W     = 3;
   localparam int FLAG_W    = 4;
   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_LD  = 1'b1
   } req_e;

endpackage

// File: rtl/ssc_rr_arb2.sv
// ssc_rr_arb2: two-way combinational grant with an optional fairness pointer.
// MODE=ARB_FIXED always favours bit 0; MODE=ARB_RR alternates on contention.
module ssc_rr_arb2
   import ssc_pkg::*;
#(
   parameter int MODE = ARB_RR
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // ptr_q names the side that wins the next contended grant
   logic ptr_q;
   logic ptr_d;
   logic pick;

   always_comb begin
      gnt   = 2'b00;
      ptr_d = ptr_q;
      pick  = (MODE == ARB_RR) ? ptr_q : 1'b0;
      if (en) begin
         unique case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
               gnt = pick ? 2'b10 : 2'b01;
               if (MODE == ARB_RR) begin
                  ptr_d = ~ptr_q;
               end
            end
            default: gnt = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/ssc_wb_arbiter.sv
// ssc_wb_arbiter: shares the register-bank write port between ALU and load.
// Optional SSC_WB_PENDING_MASK_EN adds a per-register pending mask output.
module ssc_wb_arbiter
   import ssc_pkg::*;
#(
   parameter int DW       = 32,
   parameter int AW       = REG_W,
   parameter int ARB_MODE = ARB_RR,
   parameter int CNT_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic              hold,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [AW-1:0]     alu_dest,
   input  logic [DW-1:0]     alu_data,
   input  logic              alu_set_flags,
   input  logic [FLAG_W-1:0] alu_flags,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [AW-1:0]     ld_dest,
   input  logic [DW-1:0]     ld_data,
   output logic              wEnable,
   output logic [AW-1:0]     DestReg,
   output logic [DW-1:0]     WBDataIN,
   output logic              SetFlags,
   output logic [FLAG_W-1:0] BRFlags,
   output logic [CNT_W-1:0]  drop_cnt
`ifdef SSC_WB_PENDING_MASK_EN
   ,
   output logic [2**AW-1:0]  pending_mask
`endif
);

   logic [1:0] req;
   logic [1:0] gnt;
   logic       grant_en;
   logic       g_alu;

   logic              we_q,   we_d;
   logic              sf_q,   sf_d;
   logic [AW-1:0]     dest_q, dest_d;
   logic [DW-1:0]     data_q, data_d;
   logic [FLAG_W-1:0] fl_q,   fl_d;
   logic [CNT_W-1:0]  cnt_q,  cnt_d;

   assign grant_en = clk_en & ~hold & ~rst;
   assign req      = {ld_valid, alu_valid};

   ssc_rr_arb2 #(
      .MODE (ARB_MODE)
   ) u_arb (
      .clk (clk),
      .rst (rst),
      .en  (grant_en),
      .req (req),
      .gnt (gnt)
   );

   assign alu_ready = gnt[REQ_ALU];
   assign ld_ready  = gnt[REQ_LD];

   always_comb begin
      we_d   = we_q;
      sf_d   = sf_q;
      dest_d = dest_q;
      data_d = data_q;
      fl_d   = fl_q;
      cnt_d  = cnt_q;
      g_alu  = gnt[REQ_ALU];
      if (clk_en) begin
         we_d = 1'b0;
         sf_d = 1'b0;
         if (gnt != 2'b00) begin
            dest_d = g_alu ? alu_dest : ld_dest;
            data_d = g_alu ? alu_data : ld_data;
            // PC is not writable: accept, suppress strobe, count the drop
            we_d   = (dest_d != AW'(REG_PC));
            sf_d   = g_alu & alu_set_flags;
            if (sf_d) begin
               fl_d = alu_flags;
            end
            if (!we_d && cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q   <= 1'b0;
         sf_q   <= 1'b0;
         dest_q <= '0;
         data_q <= '0;
         fl_q   <= '0;
         cnt_q  <= '0;
      end else begin
         we_q   <= we_d;
         sf_q   <= sf_d;
         dest_q <= dest_d;
         data_q <= data_d;
         fl_q   <= fl_d;
         cnt_q  <= cnt_d;
      end
   end

   assign wEnable  = we_q;
   assign SetFlags = sf_q;
   assign DestReg  = dest_q;
   assign WBDataIN = data_q;
   assign BRFlags  = fl_q;
   assign drop_cnt = cnt_q;

`ifdef SSC_WB_PENDING_MASK_EN
   always_comb begin
      pending_mask = '0;
      if (alu_valid) begin
         pending_mask[alu_dest] = 1'b1;
      end
      if (ld_valid) begin
         pending_mask[ld_dest] = 1'b1;
      end
      if (we_q) begin
         pending_mask[dest_q] = 1'b1;
      end
      pending_mask[REG_PC] = 1'b0;
   end
`endif

endmodule

// File: tb/tb_ssc_wb_arbiter.sv
// tb_ssc_wb_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of the writeback port.
module tb_ssc_wb_arbiter;
   import ssc_pkg::*;

   localparam int DW = 32;
   localparam int AW = 3;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic rst, clk_en, hold;
   logic alu_valid, alu_set_flags;
   logic [AW-1:0] alu_dest;
   logic [DW-1:0] alu_data;
   logic [3:0] alu_flags;
   logic ld_valid;
   logic [AW-1:0] ld_dest;
   logic [DW-1:0] ld_data;

   logic alu_ready, ld_ready, wEnable, SetFlags;
   logic [AW-1:0] DestReg;
   logic [DW-1:0] WBDataIN;
   logic [3:0] BRFlags;
   logic [CNT_W-1:0] drop_cnt;

   logic fx_alu_ready, fx_ld_ready, fx_we, fx_sf;
   logic [AW-1:0] fx_dest;
   logic [DW-1:0] fx_data;
   logic [3:0] fx_fl;
   logic [CNT_W-1:0] fx_cnt;
`ifdef SSC_WB_PENDING_MASK_EN
   logic [7:0] pending_mask;
   logic [7:0] fx_mask;
`endif

   int checks = 0;
   int failures = 0;

   // transaction-level model state
   bit m_ptr_ld;
   bit m_we, m_sf;
   logic [AW-1:0] m_dest;
   logic [DW-1:0] m_data;
   logic [3:0] m_fl;
   logic [7:0] m_cnt;
   bit last_ga, last_gl;
   bit e_ar, e_lr, en_m;

   logic [1:0] act_r, exp_r;
   logic [48:0] act_o, exp_o;

   always #5 clk = ~clk;

   ssc_wb_arbiter #(.DW(DW), .AW(AW), .ARB_MODE(1), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .hold(hold),
      .alu_valid(alu_valid), .alu_ready(alu_ready),
      .alu_dest(alu_dest), .alu_data(alu_data),
      .alu_set_flags(alu_set_flags), .alu_flags(alu_flags),
      .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_dest(ld_dest), .ld_data(ld_data),
      .wEnable(wEnable), .DestReg(DestReg), .WBDataIN(WBDataIN),
      .SetFlags(SetFlags), .BRFlags(BRFlags), .drop_cnt(drop_cnt)
`ifdef SSC_WB_PENDING_MASK_EN
      , .pending_mask(pending_mask)
`endif
   );

   ssc_wb_arbiter #(.DW(DW), .AW(AW), .ARB_MODE(0), .CNT_W(CNT_W)) dut_fx (
      .clk(clk), .rst(rst), .clk_en(clk_en), .hold(hold),
      .alu_valid(alu_valid), .alu_ready(fx_alu_ready),
      .alu_dest(alu_dest), .alu_data(alu_data),
      .alu_set_flags(alu_set_flags), .alu_flags(alu_flags),
      .ld_valid(ld_valid), .ld_ready(fx_ld_ready),
      .ld_dest(ld_dest), .ld_data(ld_data),
      .wEnable(fx_we), .DestReg(fx_dest), .WBDataIN(fx_data),
      .SetFlags(fx_sf), .BRFlags(fx_fl), .drop_cnt(fx_cnt)
`ifdef SSC_WB_PENDING_MASK_EN
      , .pending_mask(fx_mask)
`endif
   );

   // grant rule: single valid wins; contention goes to the pointed side
   always_comb begin
      en_m = !rst && !hold && clk_en;
      e_ar = en_m && alu_valid && (!ld_valid || !m_ptr_ld);
      e_lr = en_m && ld_valid && !e_ar;
      exp_r = {e_ar, e_lr};
   end

   assign act_r = {alu_ready, ld_ready};
   assign act_o = {wEnable, SetFlags,
                   wEnable ? DestReg : 3'd0,
                   wEnable ? WBDataIN : 32'd0,
                   SetFlags ? BRFlags : 4'd0,
                   drop_cnt};
   always_comb exp_o = {m_we, m_sf,
                        m_we ? m_dest : 3'd0,
                        m_we ? m_data : 32'd0,
                        m_sf ? m_fl : 4'd0,
                        m_cnt};

   task automatic tick();
      logic [AW-1:0] d;
      @(posedge clk);
      last_ga = e_ar;
      last_gl = e_lr;
      if (rst) begin
         m_we = 0; m_sf = 0; m_dest = 0; m_data = 0;
         m_fl = 0; m_cnt = 0; m_ptr_ld = 0;
      end else if (clk_en) begin
         m_we = 0;
         m_sf = 0;
         if (last_ga || last_gl) begin
            d = last_ga ? alu_dest : ld_dest;
            m_dest = d;
            m_data = last_ga ? alu_data : ld_data;
            m_we = (d != 0);
            m_sf = last_ga && alu_set_flags;
            if (m_sf) m_fl = alu_flags;
            if (d == 0 && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            if (alu_valid && ld_valid) m_ptr_ld = last_ga;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      alu_valid = 0; ld_valid = 0; hold = 0; clk_en = 1;
      alu_set_flags = 0; alu_flags = 0;
   endtask

   task automatic test_reset();
      rst = 1; clk_en = 0; hold = 0;
      alu_valid = 1; alu_dest = 3'd3; alu_data = 32'h1111_2222;
      alu_set_flags = 0; alu_flags = 0;
      ld_valid = 0; ld_dest = 0; ld_data = 0;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (act_r !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready cyc=%0d got=%b want=00", i, act_r);
         end
         tick();
         clk_en = 1;
      end
      checks++;
      if ({wEnable, SetFlags, DestReg, WBDataIN, BRFlags, drop_cnt} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got we=%b sf=%b d=%0d data=%h fl=%h cnt=%0d want all 0",
                  wEnable, SetFlags, DestReg, WBDataIN, BRFlags, drop_cnt);
      end
      rst = 0;
      #1;
      checks++;
      if (act_r !== 2'b10) begin
         failures++;
         $display("FAIL reset_release_ready got=%b want=10", act_r);
      end
      tick();
      checks++;
      if ({wEnable, DestReg, WBDataIN} !== {1'b1, 3'd3, 32'h1111_2222}) begin
         failures++;
         $display("FAIL first_write got we=%b d=%0d data=%h want 1/3/11112222",
                  wEnable, DestReg, WBDataIN);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_alu_only();
      alu_valid = 1; alu_dest = 3'd3; alu_data = 32'hDEADBEEF;
      alu_set_flags = 1; alu_flags = 4'b1010;
      #1;
      tick();
      alu_valid = 0; alu_set_flags = 0;
      checks++;
      if ({wEnable, DestReg, WBDataIN, SetFlags, BRFlags} !==
          {1'b1, 3'd3, 32'hDEADBEEF, 1'b1, 4'b1010}) begin
         failures++;
         $display("FAIL alu_only got we=%b d=%0d data=%h sf=%b fl=%b",
                  wEnable, DestReg, WBDataIN, SetFlags, BRFlags);
      end
      tick();
      checks++;
      if ({wEnable, SetFlags} !== 2'b00) begin
         failures++;
         $display("FAIL alu_only_clear got we=%b sf=%b want 0 0", wEnable, SetFlags);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] want_rr [4];
      want_rr = '{2'b10, 2'b01, 2'b10, 2'b01};
      alu_valid = 1; alu_dest = 3'd1; alu_data = 32'hA1A1_0001;
      ld_valid = 1; ld_dest = 3'd2; ld_data = 32'hB2B2_0002;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (act_r !== want_rr[i]) begin
            failures++;
            $display("FAIL rr_grant cyc=%0d got=%b want=%b", i, act_r, want_rr[i]);
         end
         checks++;
         if ({fx_alu_ready, fx_ld_ready} !== 2'b10) begin
            failures++;
            $display("FAIL fixed_grant cyc=%0d got=%b want=10", i,
                     {fx_alu_ready, fx_ld_ready});
         end
         tick();
         checks++;
         if (act_o !== exp_o) begin
            failures++;
            $display("FAIL rr_out cyc=%0d got=%h want=%h", i, act_o, exp_o);
         end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_clk_en();
      int seen;
      seen = 0;
      clk_en = 0; alu_valid = 1; alu_dest = 3'd4; alu_data = 32'h0C0C_4444;
      #1;
      checks++;
      if (act_r !== 2'b00) begin
         failures++;
         $display("FAIL clken_ready_off got=%b want=00", act_r);
      end
      tick();
      seen += wEnable;
      clk_en = 1;
      #1;
      checks++;
      if (act_r !== 2'b10) begin
         failures++;
         $display("FAIL clken_ready_on got=%b want=10", act_r);
      end
      tick();
      seen += wEnable;
      alu_valid = 0; clk_en = 0;
      tick();
      checks++;
      if ({wEnable, DestReg, WBDataIN} !== {1'b1, 3'd4, 32'h0C0C_4444}) begin
         failures++;
         $display("FAIL clken_hold got we=%b d=%0d data=%h want 1/4/0c0c4444",
                  wEnable, DestReg, WBDataIN);
      end
      clk_en = 1;
      tick();
      seen += wEnable;
      tick();
      seen += wEnable;
      checks++;
      if (seen != 1) begin
         failures++;
         $display("FAIL clken_once got=%0d writes want=1", seen);
      end
   endtask

   task automatic test_hold();
      alu_valid = 1; alu_dest = 3'd6; alu_data = 32'h6666_0006;
      #1;
      tick();
      alu_valid = 0; hold = 1;
      ld_valid = 1; ld_dest = 3'd5; ld_data = 32'h5555_0005;
      #1;
      checks++;
      if (act_r !== 2'b00 || wEnable !== 1'b1 || DestReg !== 3'd6) begin
         failures++;
         $display("FAIL hold_block got rdy=%b we=%b d=%0d want 00/1/6",
                  act_r, wEnable, DestReg);
      end
      tick();
      checks++;
      if (act_o !== exp_o || wEnable !== 1'b0) begin
         failures++;
         $display("FAIL hold_idle got=%h want=%h", act_o, exp_o);
      end
      hold = 0;
      #1;
      checks++;
      if (act_r !== 2'b01) begin
         failures++;
         $display("FAIL hold_release got=%b want=01", act_r);
      end
      tick();
      ld_valid = 0;
      checks++;
      if ({wEnable, DestReg, WBDataIN, SetFlags} !== {1'b1, 3'd5, 32'h5555_0005, 1'b0}) begin
         failures++;
         $display("FAIL hold_ld_write got we=%b d=%0d data=%h sf=%b",
                  wEnable, DestReg, WBDataIN, SetFlags);
      end
      tick();
   endtask

   task automatic test_drop();
      int we_seen, nrdy;
      we_seen = 0; nrdy = 0;
      alu_valid = 1; alu_dest = 3'd0; alu_set_flags = 1; alu_flags = 4'b0110;
      #1;
      tick();
      alu_valid = 0; alu_set_flags = 0;
      checks++;
      if ({wEnable, SetFlags, BRFlags, drop_cnt} !== {1'b0, 1'b1, 4'b0110, 8'd1}) begin
         failures++;
         $display("FAIL drop_alu_flags got we=%b sf=%b fl=%b cnt=%0d want 0/1/0110/1",
                  wEnable, SetFlags, BRFlags, drop_cnt);
      end
      ld_valid = 1; ld_dest = 3'd0;
      for (int i = 0; i < 300; i++) begin
         ld_data = $urandom;
         #1;
         if (ld_ready !== 1'b1) nrdy++;
         tick();
         if (wEnable !== 1'b0) we_seen++;
         if (i == 8) begin
            checks++;
            if (drop_cnt !== 8'd10) begin
               failures++;
               $display("FAIL drop_count got=%0d want=10", drop_cnt);
            end
         end
      end
      ld_valid = 0;
      checks++;
      if (we_seen != 0 || nrdy != 0) begin
         failures++;
         $display("FAIL drop_we got we_cycles=%0d unready=%0d want 0 0", we_seen, nrdy);
      end
      checks++;
      if (drop_cnt !== 8'd255) begin
         failures++;
         $display("FAIL drop_saturate got=%0d want=255", drop_cnt);
      end
      tick();
   endtask

`ifdef SSC_WB_PENDING_MASK_EN
   task automatic test_pending_mask();
      hold = 1; ld_valid = 1; ld_dest = 3'd5; ld_data = 32'h0000_5A5A;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (pending_mask !== 8'b0010_0000) begin
            failures++;
            $display("FAIL mask_hold cyc=%0d got=%b want=00100000", i, pending_mask);
         end
         tick();
      end
      hold = 0;
      #1;
      tick();
      ld_valid = 0;
      #1;
      checks++;
      if (pending_mask !== 8'b0010_0000) begin
         failures++;
         $display("FAIL mask_outreg got=%b want=00100000", pending_mask);
      end
      tick();
      checks++;
      if (pending_mask !== 8'b0) begin
         failures++;
         $display("FAIL mask_clear got=%b want=0", pending_mask);
      end
   endtask
`endif

   task automatic test_random();
      bit akeep, lkeep;
      int bad_r, bad_o;
      bad_r = 0; bad_o = 0;
      for (int i = 0; i < 600; i++) begin
         akeep = alu_valid && !last_ga && !rst;
         lkeep = ld_valid && !last_gl && !rst;
         rst = ($urandom_range(0, 59) == 0);
         clk_en = ($urandom_range(0, 4) != 0);
         hold = ($urandom_range(0, 6) == 0);
         if (!akeep) begin
            alu_valid = 1'($urandom_range(0, 1));
            alu_dest = AW'($urandom_range(0, 7));
            alu_data = $urandom;
            alu_set_flags = 1'($urandom_range(0, 1));
            alu_flags = 4'($urandom_range(0, 15));
         end
         if (!lkeep) begin
            ld_valid = 1'($urandom_range(0, 1));
            ld_dest = AW'($urandom_range(0, 7));
            ld_data = $urandom;
         end
         #1;
         checks++;
         if (act_r !== exp_r) begin
            failures++;
            if (bad_r++ < 5)
               $display("FAIL rand_ready cyc=%0d got=%b want=%b", i, act_r, exp_r);
         end
         tick();
         checks++;
         if (act_o !== exp_o) begin
            failures++;
            if (bad_o++ < 5)
               $display("FAIL rand_out cyc=%0d got=%h want=%h", i, act_o, exp_o);
         end
      end
      rst = 0;
      idle_inputs();
      tick();
   endtask

   initial begin
      m_ptr_ld = 0; m_we = 0; m_sf = 0; m_dest = 0; m_data = 0;
      m_fl = 0; m_cnt = 0; last_ga = 0; last_gl = 0;
      test_reset();
      test_alu_only();
      test_round_robin();
      test_clk_en();
      test_hold();
      test_drop();
`ifdef SSC_WB_PENDING_MASK_EN
      test_pending_mask();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
